sdram_burst_writer: RTL and testbench
=====================================

// Module: sdram_burst_writer
// PURPOSE
//  Stage between the pixel CDC FIFO (CLK-side read port) and the SDRAM controller write path.
//  Pops pixels from the FIFO and packs BurstLength words into a line buffer.
//  Issues one SDRAM write burst per full buffer, at a linear frame address that wraps per frame.
//  Pulses o_frame_done after the last burst of each frame.
// PARAMETERS
//  FrameWidth      640  pixels per line
//  FrameHeight     480  lines per frame; FrameWidth*FrameHeight must be a multiple of BurstLength
//  PixelBitWidth   16   FIFO word width = SDRAM word width
//  AddressWidth    24   SDRAM linear address width (bank+row+col)
//  BurstLength     8    words per burst, power of two
//  BaseAddress     0    SDRAM word address of pixel 0
// PORTS
//  CLK            in   1   system clock (SDRAM domain)
//  RST            in   1   asynchronous reset, active-high
//  o_fifo_rd_en   out  1   FIFO pop; standard (non-FWFT) FIFO, i_fifo_data valid 1 cycle later
//  i_fifo_data    in   PixelBitWidth  FIFO output word
//  i_fifo_empty   in   1   FIFO empty flag
//  o_enable       out  1   SDRAM command request
//  o_rw           out  1   0 = write (constant 0 from this block)
//  o_addr         out  AddressWidth  burst start address
//  o_data         out  PixelBitWidth current burst word
//  i_busy         in   1   controller busy; command accepted on o_enable & !i_busy
//  i_valid_wr     in   1   controller consumed o_data this cycle
//  o_frame_done   out  1   1-cycle pulse after last word of a frame is consumed
//  i_vsync        in   1   only with SDRAM_BW_FRAME_SYNC_EN: frame-start pulse (CLK domain)
// BEHAVIOUR
//  Reset: all outputs 0; o_addr = BaseAddress; fill/word counters 0; state FILL.
//  FILL: o_fifo_rd_en = !i_fifo_empty && (fill + pending_read) < BurstLength.
//   Data captured into buf[fill] the cycle after rd_en; fill increments on capture.
//   At fill == BurstLength with no read pending -> REQ. Never pops more than BurstLength.
//  REQ: o_enable = 1, o_rw = 0, o_addr = burst address, o_data = buf[0]; held stable.
//   Request drops the cycle after acceptance (o_enable & !i_busy) -> DATA.
//  DATA: each i_valid_wr cycle consumes o_data; word index advances; o_data = buf[index] next cycle.
//   i_valid_wr may be non-consecutive; o_data holds while it is low.
//   On the BurstLength-th i_valid_wr: fill <= 0, address += BurstLength -> FILL.
//   If that burst ends the frame: address <= BaseAddress, o_frame_done = 1 for one cycle.
//  No FIFO pops in REQ/DATA; the upstream FIFO absorbs backpressure.
//   FIFO overflow is the FIFO's concern, not this block's.
//  i_valid_wr outside DATA is ignored. i_fifo_empty while a read is pending is irrelevant;
//   the pending word is still captured.
//  Address arithmetic: offset counter width = clog2(FrameWidth*FrameHeight); o_addr = BaseAddress + offset.
//   Offset wraps to 0 exactly at FrameWidth*FrameHeight.
//  Reset mid-burst aborts immediately; the partial burst is lost; next burst starts at BaseAddress.
// CONFIGURATION
//  SDRAM_BW_FRAME_SYNC_EN defined: i_vsync port present.
//   i_vsync in FILL: drops the buffered partial burst (fill <= 0); any in-flight FIFO word is discarded;
//   offset <= 0; no o_frame_done.
//   i_vsync in REQ/DATA: latched; the current burst completes, then the offset is realigned to 0.
//  SDRAM_BW_FRAME_SYNC_EN not defined: port absent; alignment relies solely on pixel count from reset.
// STRUCTURE
//  Shared package/header: state encoding (FILL, REQ, DATA), BurstLength, frame word count localparam.
//  Same header is used by the SDRAM controller and the readback path.
//  One sub-module: burst_line_buffer (BurstLength x PixelBitWidth regfile, 1 write port, 1 async read port).
//  FSM and address counter stay in this module.
// TESTING
//  FIFO holds 8 words 0x0001..0x0008, i_busy = 0, i_valid_wr every cycle in DATA
//   -> 8 pops; one request at addr 0; o_data sequence 0x0001..0x0008; next burst addr 8.
//  i_busy high 5 cycles during REQ
//   -> o_enable, o_addr and o_data stay stable all 5 cycles; accepted on first !i_busy cycle.
//  i_valid_wr pattern 1,0,0,1,1,0,1... -> each word presented until consumed; no skips or duplicates.
//  FrameWidth = 8, FrameHeight = 2 (16 words)
//   -> bursts at 0 and 8; o_frame_done pulses once after word 16; third burst at addr 0.
//  FIFO empty after 5 words -> stays in FILL, o_enable = 0; resumes when data arrives.
//   RST asserted in DATA -> all outputs 0 next edge.
//  SDRAM_BW_FRAME_SYNC_EN: i_vsync after 3 words buffered -> those words dropped; next burst at addr 0.

Source files
------------

// File: rtl/sdram_burst_writer_pkg.sv
// Shared definitions for the SDRAM burst writer, controller and readback path:
// FSM state encoding, default burst/frame geometry and a width helper.
package sdram_burst_writer_pkg;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2
   } bw_state_e;

   localparam int unsigned BW_BURST_LEN    = 8;
   localparam int unsigned BW_FRAME_WIDTH  = 640;
   localparam int unsigned BW_FRAME_HEIGHT = 480;
   localparam int unsigned BW_FRAME_WORDS  = BW_FRAME_WIDTH * BW_FRAME_HEIGHT;

   // Counter width for values 0..v-1, never narrower than one bit.
   function automatic int unsigned bw_clog2_min1(input int unsigned v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/sdram_burst_writer_line_buffer.sv
// Burst line buffer: Depth x Width register file, one synchronous write port
// and one asynchronous read port. Contents are data only and are never reset.
module burst_line_buffer
   import sdram_burst_writer_pkg::*;
#(
   parameter int unsigned Depth = BW_BURST_LEN,
   parameter int unsigned Width = 16,
   localparam int unsigned AW   = bw_clog2_min1(Depth)
) (
   input  logic             CLK,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [Width-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [Width-1:0] o_rdata
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge CLK) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sdram_burst_writer.sv
// Packs FIFO pixels into BurstLength-word bursts and issues SDRAM write bursts at a
// linear per-frame address. Optional macro SDRAM_BW_FRAME_SYNC_EN adds i_vsync realignment.
module sdram_burst_writer
   import sdram_burst_writer_pkg::*;
#(
   parameter int unsigned             FrameWidth    = BW_FRAME_WIDTH,
   parameter int unsigned             FrameHeight   = BW_FRAME_HEIGHT,
   parameter int unsigned             PixelBitWidth = 16,
   parameter int unsigned             AddressWidth  = 24,
   parameter int unsigned             BurstLength   = BW_BURST_LEN,
   parameter logic [AddressWidth-1:0] BaseAddress   = '0
) (
   input  logic                     CLK,
   input  logic                     RST,
   output logic                     o_fifo_rd_en,
   input  logic [PixelBitWidth-1:0] i_fifo_data,
   input  logic                     i_fifo_empty,
   output logic                     o_enable,
   output logic                     o_rw,
   output logic [AddressWidth-1:0]  o_addr,
   output logic [PixelBitWidth-1:0] o_data,
   input  logic                     i_busy,
   input  logic                     i_valid_wr,
   output logic                     o_frame_done
`ifdef SDRAM_BW_FRAME_SYNC_EN
   ,
   input  logic                     i_vsync
`endif
);

   localparam int unsigned FrameWords = FrameWidth * FrameHeight;
   localparam int unsigned OffW       = bw_clog2_min1(FrameWords);
   localparam int unsigned IdxW       = bw_clog2_min1(BurstLength);
   localparam int unsigned FillW      = IdxW + 1;

   localparam logic [FillW-1:0] FillFull = FillW'(BurstLength);
   localparam logic [FillW:0]   FillLim  = (FillW+1)'(BurstLength);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(BurstLength - 1);
   localparam logic [OffW:0]    OffEnd   = (OffW+1)'(FrameWords);
   localparam logic [OffW:0]    OffStep  = (OffW+1)'(BurstLength);

   bw_state_e             state_q, state_d;
   logic [FillW-1:0]      fill_q, fill_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [OffW-1:0]       off_q, off_d;
   logic                  pend_q, pend_d;
   logic                  done_q, done_d;

   logic                  rd_en;
   logic                  buf_we;
   logic [PixelBitWidth-1:0] buf_rdata;
   logic [FillW:0]        fill_plus_pend;
   logic [OffW:0]         off_next;
   logic                  vsync_w;
   logic                  sync_pend_w;

`ifdef SDRAM_BW_FRAME_SYNC_EN
   logic sync_q, sync_d;
   assign vsync_w     = i_vsync;
   assign sync_pend_w = sync_q;
`else
   assign vsync_w     = 1'b0;
   assign sync_pend_w = 1'b0;
`endif

   assign fill_plus_pend = {1'b0, fill_q} + {{FillW{1'b0}}, pend_q};
   assign off_next       = {1'b0, off_q} + OffStep;

   burst_line_buffer #(
      .Depth (BurstLength),
      .Width (PixelBitWidth)
   ) u_line_buffer (
      .CLK     (CLK),
      .i_we    (buf_we),
      .i_waddr (fill_q[IdxW-1:0]),
      .i_wdata (i_fifo_data),
      .i_raddr (idx_q),
      .o_rdata (buf_rdata)
   );

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      off_d   = off_q;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      rd_en   = 1'b0;
      buf_we  = 1'b0;
`ifdef SDRAM_BW_FRAME_SYNC_EN
      sync_d  = sync_q;
`endif
      case (state_q)
         ST_FILL: begin
            if (vsync_w) begin
               // Frame restart: drop the partial burst and any word still in flight.
               fill_d = '0;
               off_d  = '0;
            end else begin
               rd_en  = !i_fifo_empty && (fill_plus_pend < FillLim);
               pend_d = rd_en;
               if (pend_q) begin
                  buf_we = 1'b1;
                  fill_d = fill_q + FillW'(1);
               end
               if (fill_q == FillFull && !pend_q) state_d = ST_REQ;
            end
         end
         ST_REQ: begin
`ifdef SDRAM_BW_FRAME_SYNC_EN
            sync_d = sync_q | i_vsync;
`endif
            if (!i_busy) state_d = ST_DATA;
         end
         ST_DATA: begin
`ifdef SDRAM_BW_FRAME_SYNC_EN
            sync_d = sync_q | i_vsync;
`endif
            if (i_valid_wr) begin
               if (idx_q == IdxLast) begin
                  idx_d   = '0;
                  fill_d  = '0;
                  state_d = ST_FILL;
                  if (sync_pend_w || vsync_w) begin
                     off_d = '0;
                  end else if (off_next == OffEnd) begin
                     off_d  = '0;
                     done_d = 1'b1;
                  end else begin
                     off_d = off_next[OffW-1:0];
                  end
`ifdef SDRAM_BW_FRAME_SYNC_EN
                  sync_d = 1'b0;
`endif
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_FILL;
         fill_q  <= '0;
         idx_q   <= '0;
         off_q   <= '0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SDRAM_BW_FRAME_SYNC_EN
         sync_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
`ifdef SDRAM_BW_FRAME_SYNC_EN
         sync_q  <= sync_d;
`endif
      end
   end

   assign o_fifo_rd_en = rd_en;
   assign o_enable     = (state_q == ST_REQ);
   assign o_rw         = 1'b0;
   assign o_addr       = BaseAddress + AddressWidth'(off_q);
   // Buffer contents are meaningless while filling, so the data bus is held at zero there.
   assign o_data       = (state_q == ST_FILL) ? '0 : buf_rdata;
   assign o_frame_done = done_q;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Testbench for sdram_burst_writer: table-driven bursts, corner sequences and a
// randomized phase against a queue-based FIFO/SDRAM reference model.
module tb_sdram_burst_writer;

   localparam int FW    = 8;
   localparam int FH    = 2;
   localparam int PW    = 16;
   localparam int AW    = 24;
   localparam int BL    = 8;
   localparam int FRAME = FW * FH;
   localparam int BPF   = FRAME / BL;
   localparam logic [AW-1:0] BASE = '0;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          o_fifo_rd_en;
   logic [PW-1:0] i_fifo_data = '0;
   logic          i_fifo_empty = 1'b1;
   logic          o_enable;
   logic          o_rw;
   logic [AW-1:0] o_addr;
   logic [PW-1:0] o_data;
   logic          i_busy = 1'b0;
   logic          i_valid_wr = 1'b0;
   logic          o_frame_done;

   always #5 CLK = ~CLK;

   sdram_burst_writer #(
      .FrameWidth    (FW),
      .FrameHeight   (FH),
      .PixelBitWidth (PW),
      .AddressWidth  (AW),
      .BurstLength   (BL),
      .BaseAddress   (BASE)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .o_fifo_rd_en (o_fifo_rd_en),
      .i_fifo_data  (i_fifo_data),
      .i_fifo_empty (i_fifo_empty),
      .o_enable     (o_enable),
      .o_rw         (o_rw),
      .o_addr       (o_addr),
      .o_data       (o_data),
      .i_busy       (i_busy),
      .i_valid_wr   (i_valid_wr),
      .o_frame_done (o_frame_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [PW-1:0] fifo_q[$];
   logic [PW-1:0] exp_q[$];
   int  popped, consumed, bursts, done_seen, req_seen, last_req_len, vcyc, busy_n, words_in_burst;
   bit  in_burst, done_due, rand_mode, prev_en, prev_busy;
   logic [AW-1:0] last_acc_addr, prev_addr;
   logic [PW-1:0] prev_data;
   logic [7:0]    vmask;

   typedef struct {
      logic [PW-1:0] first;
      int            busy;
      logic [7:0]    mask;
      logic [AW-1:0] exp_addr;
      int            exp_done;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      popped = 0; consumed = 0; bursts = 0; req_seen = 0; words_in_burst = 0;
      in_burst = 0; done_due = 0; prev_en = 0; prev_busy = 0;
   endtask

   // Reference view: popped words form bursts of BL in order; burst k lands at BASE + (k*BL mod FRAME).
   task automatic monitor();
      logic [AW-1:0] ea;
      logic [PW-1:0] ew;
      if (RST) return;
      check("frame_done", o_frame_done, done_due);
      if (o_frame_done) done_seen++;
      done_due = 0;
      check("overpop", (popped - consumed) <= BL, 1);
      if (in_burst && i_valid_wr) begin
         ew = 'x;
         if (exp_q.size() > 0) ew = exp_q.pop_front();
         check("burst_word", o_data, ew);
         consumed++;
         words_in_burst++;
         if (words_in_burst == BL) begin
            in_burst = 0;
            bursts++;
            done_due = ((bursts % BPF) == 0);
         end
      end
      if (o_enable) begin
         check("rw", o_rw, 0);
         check("req_during_burst", in_burst, 0);
         if (prev_en && prev_busy) begin
            check("req_addr_stable", o_addr, prev_addr);
            check("req_data_stable", o_data, prev_data);
         end
         prev_addr = o_addr;
         prev_data = o_data;
         if (!i_busy) begin
            ea = BASE + AW'((bursts * BL) % FRAME);
            ew = 'x;
            if (exp_q.size() > 0) ew = exp_q[0];
            check("req_addr", o_addr, ea);
            check("req_first_word", o_data, ew);
            last_acc_addr  = o_addr;
            last_req_len   = req_seen + 1;
            in_burst       = 1;
            words_in_burst = 0;
            req_seen       = 0;
         end else begin
            req_seen++;
         end
      end
      prev_en   = o_enable;
      prev_busy = i_busy;
   endtask

   task automatic cycle();
      bit pop_now;
      logic [PW-1:0] w;
      @(negedge CLK);
      monitor();
      pop_now = o_fifo_rd_en && (fifo_q.size() > 0);
      @(posedge CLK);
      #1;
      if (pop_now) begin
         w = fifo_q.pop_front();
         i_fifo_data = w;
         exp_q.push_back(w);
         popped++;
      end
      i_fifo_empty = (fifo_q.size() == 0);
      if (rand_mode) begin
         i_busy     = ($urandom_range(0, 2) == 0);
         i_valid_wr = $urandom_range(0, 1) != 0;
      end else begin
         i_busy     = o_enable && (req_seen < busy_n);
         i_valid_wr = vmask[vcyc % 8];
         vcyc++;
      end
   endtask

   task automatic push(input logic [PW-1:0] w);
      fifo_q.push_back(w);
      i_fifo_empty = 1'b0;
   endtask

   task automatic wait_bursts(input int target, input int budget, input string name);
      int n = 0;
      while (bursts < target && n < budget) begin
         cycle();
         n++;
      end
      check({name, "_in_time"}, bursts >= target, 1);
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, d0, b0, n;
      vecs[0] = '{16'h0001, 0, 8'hFF,       24'h0, 0};
      vecs[1] = '{16'h0011, 5, 8'b0101_1001, 24'h8, 1};
      vecs[2] = '{16'h0021, 0, 8'hFF,       24'h0, 0};
      vecs[3] = '{16'h00A0, 2, 8'b1011_0110, 24'h8, 1};

      model_reset();
      done_seen = 0; vcyc = 0; busy_n = 0; vmask = 8'hFF; rand_mode = 0;
      last_acc_addr = '0; last_req_len = 0;

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_rd_en", o_fifo_rd_en, 0);
      check("rst_enable", o_enable, 0);
      check("rst_rw", o_rw, 0);
      check("rst_addr", o_addr, BASE);
      check("rst_data", o_data, 0);
      check("rst_frame_done", o_frame_done, 0);
      @(posedge CLK);
      #1 RST = 1'b0;

      // Table-driven bursts across two frames of 16 words
      for (int k = 0; k < 4; k++) begin
         p0 = popped; d0 = done_seen; b0 = bursts;
         busy_n = vecs[k].busy;
         vmask  = vecs[k].mask;
         for (int j = 0; j < BL; j++) push(PW'(vecs[k].first + PW'(j)));
         wait_bursts(b0 + 1, 300, "vec");
         check("vec_addr", last_acc_addr, vecs[k].exp_addr);
         check("vec_done", done_seen - d0, vecs[k].exp_done);
         check("vec_pops", popped - p0, BL);
         check("vec_req_len", last_req_len, vecs[k].busy + 1);
      end

      // FIFO runs dry after 5 words: no request until the burst is complete
      busy_n = 0; vmask = 8'hFF; p0 = popped; b0 = bursts;
      for (int j = 0; j < 5; j++) push(PW'(16'h0100 + j));
      repeat (12) cycle();
      check("partial_enable", o_enable, 0);
      check("partial_rd_en", o_fifo_rd_en, 0);
      check("partial_pops", popped - p0, 5);
      for (int j = 5; j < 8; j++) push(PW'(16'h0100 + j));
      wait_bursts(b0 + 1, 300, "resume");
      check("resume_addr", last_acc_addr, BASE);

      // Reset in the middle of a data phase
      vmask = 8'b0101_1001;
      for (int j = 0; j < BL; j++) push(PW'(16'h0200 + j));
      n = 0;
      while (!(in_burst && words_in_burst >= 3) && n < 300) begin
         cycle();
         n++;
      end
      check("mid_burst_reached", in_burst && words_in_burst >= 3, 1);
      RST = 1'b1;
      @(negedge CLK);
      check("abort_enable", o_enable, 0);
      check("abort_rd_en", o_fifo_rd_en, 0);
      check("abort_data", o_data, 0);
      check("abort_addr", o_addr, BASE);
      check("abort_frame_done", o_frame_done, 0);
      fifo_q.delete();
      i_fifo_empty = 1'b1;
      model_reset();
      @(posedge CLK);
      #1 RST = 1'b0;
      vmask = 8'hFF;
      for (int j = 0; j < BL; j++) push(PW'(16'h0300 + j));
      wait_bursts(1, 300, "post_reset");
      check("post_reset_addr", last_acc_addr, BASE);

      // Randomized traffic with random backpressure
      rand_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) push(PW'($urandom));
         cycle();
      end
      while (((popped + fifo_q.size()) % BL) != 0) push(PW'($urandom));
      rand_mode = 0; vmask = 8'hFF; busy_n = 0;
      wait_bursts((popped + fifo_q.size()) / BL, 6000, "drain");
      check("drain_left", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
